// File: rtl/regex_if.sv
// Symbol stream in, match pulse out.
// The source drives i/i_c and observes o; the matcher is the slave.
interface regex_if;
  logic i;    // symbol valid
  logic i_c;  // symbol value
  logic o;    // registered match pulse

  modport master (output i, output i_c, input o);
  modport slave  (input i, input i_c, output o);
endinterface

// File: rtl/regex.sv
// Streaming matcher for the unanchored pattern 1{MIN_ONES,}0{ZEROS}.
// The pattern is never stored. Two run-length counters track progress:
//   ones_cnt  - length of the latest run of ones (saturates at all-ones)
//   zeros_cnt - zeros seen since that run ended (saturates at ZEROS+1)
// o is a one-cycle registered pulse on the edge that consumes the completing zero.
module regex #(
  parameter int MIN_ONES = 1,
  parameter int ZEROS    = 15,
  parameter int CW       = 8
) (
  input  logic   clk,
  input  logic   reset,
  regex_if.slave bus
);

  localparam logic [CW-1:0] ONES_MAX = '1;
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_ONES);
  localparam logic [CW-1:0] ZEROS_C  = CW'(ZEROS);
  localparam logic [CW-1:0] ZSAT     = CW'(ZEROS + 1);

  logic [CW-1:0] ones_cnt, ones_n;
  logic [CW-1:0] zeros_cnt, zeros_n;
  logic [CW-1:0] zinc;
  logic          o_q, o_n;

  // Run-length state and the match pulse register. Reset wins over a valid symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_cnt  <= '0;
      zeros_cnt <= '0;
      o_q       <= 1'b0;
    end else begin
      ones_cnt  <= ones_n;
      zeros_cnt <= zeros_n;
      o_q       <= o_n;
    end
  end

  // Next-state: a 1 extends or restarts the ones run, a 0 extends the zeros
  // run, and a bubble holds both. The pulse is only ever asserted for one edge.
  always_comb begin
    ones_n  = ones_cnt;
    zeros_n = zeros_cnt;
    o_n     = 1'b0;
    // Saturated increment: once past ZEROS the count parks at ZEROS+1, so
    // surplus zeros cannot produce a second pulse.
    zinc    = (zeros_cnt == ZSAT) ? zeros_cnt : zeros_cnt + 1'b1;
    if (bus.i) begin
      if (bus.i_c) begin
        // Any zero since the last one means this 1 starts a fresh run.
        if (zeros_cnt != '0)
          ones_n = {{(CW-1){1'b0}}, 1'b1};
        else if (ones_cnt != ONES_MAX)
          ones_n = ones_cnt + 1'b1;
        zeros_n = '0;
      end else begin
        zeros_n = zinc;
        o_n     = (zinc == ZEROS_C) && (ones_cnt >= MIN_C);
      end
    end
  end

  assign bus.o = o_q;

endmodule

// File: tb/tb_regex.sv
// Directed bench for regex: two instances (MIN_ONES=1 and MIN_ONES=3) share
// one symbol stream; each vector carries the expected o of both.
module tb_regex;

  logic clk = 1'b0;
  logic reset;

  regex_if ifa ();
  regex_if ifb ();

  regex #(.MIN_ONES(1), .ZEROS(15), .CW(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  regex #(.MIN_ONES(3), .ZEROS(15), .CW(8)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit v;
    bit c;
    bit ea;  // expected o of dut_a after the edge
    bit eb;  // expected o of dut_b after the edge
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input bit r, input bit v, input bit c, input bit ea, input bit eb);
    vec_t t;
    t.rst = r; t.v = v; t.c = c; t.ea = ea; t.eb = eb;
    tbl.push_back(t);
  endtask

  task automatic ones_run(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // n valid zeros; pulse expected on the ka-th (dut_a) / kb-th (dut_b), 0 = none
  task automatic zeros_run(input int n, input int ka, input int kb);
    for (int k = 1; k <= n; k++) push(1'b0, 1'b1, 1'b0, k == ka, k == kb);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input bit r, input bit v, input bit c);
    reset = r;
    ifa.i = v; ifa.i_c = c;
    ifb.i = v; ifb.i_c = c;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: o=%0b expected %0b", name, act, exp);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);

    // reset, then idle
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    // basic match: 111 + 15 zeros (3 ones satisfies MIN_ONES=3 too)
    ones_run(3);  zeros_run(15, 15, 15);
    // 5 ones + 16 zeros: one pulse on the 15th, none on the 16th, then a bubble
    ones_run(5);  zeros_run(16, 15, 15);  idle(1);
    // broken run: 1, 14 zeros, 1, 14 zeros -> none; one more zero -> pulse
    ones_run(1);  zeros_run(14, 0, 0);
    ones_run(1);  zeros_run(14, 0, 0);  zeros_run(1, 1, 0);
    // reset overrides a simultaneous valid 1; 20 leading zeros never match
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    zeros_run(20, 0, 0);
    // bubbles interleaved with the zeros neither break nor extend the run
    ones_run(1);
    for (int k = 1; k <= 15; k++) begin
      push(1'b0, 1'b1, 1'b0, k == 15, 1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // reset mid-stream discards the partial match
    ones_run(1);  zeros_run(10, 0, 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    zeros_run(5, 0, 0);
    // MIN_ONES boundary: 11 is too short for dut_b, 111 is enough
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ones_run(2);  zeros_run(15, 15, 0);
    ones_run(3);  zeros_run(15, 15, 15);
    // ones run well past 2^CW-1 saturates and still qualifies
    ones_run(300); zeros_run(15, 15, 15);
    idle(2);

    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clk);
      drive(tbl[n].rst, tbl[n].v, tbl[n].c);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d dut_a", n), ifa.o, tbl[n].ea);
      check($sformatf("vec%0d dut_b", n), ifb.o, tbl[n].eb);
    end

    // Hand sequence: the pulse holds for the whole cycle after the completing
    // edge and drops at the next edge even though another zero is consumed.
    @(negedge clk); drive(1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk); drive(1'b0, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    check("hand pre_complete", ifa.o, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("hand complete_edge", ifa.o, 1'b1);
    check("hand complete_b", ifb.o, 1'b0);
    @(negedge clk);
    check("hand mid_cycle", ifa.o, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("hand next_edge", ifa.o, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
